// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_reader_pkg: shared FSM encoding and parameter defaults for the RAM stream reader
package ram_stream_reader_pkg;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// stream_fifo: synchronous FIFO (DATA_WIDTH x DEPTH) with full/empty/count
// ports: clk, rst (async, high), wr_en/wr_data push, rd_en pop, rd_data oldest entry (0 when empty),
//        full, empty, count occupancy
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_rd, do_wr;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_rd = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: reads a burst of words from a 1-cycle-latency sync RAM into a ready/valid stream
// ports: clk, rst (async, high); start/baseAddr/length request a burst;
//        ramAddr/ramRead/ramWriteEn/ramDout talk to sync_ram; outData/outValid/outReady is the stream;
//        busy high outside IDLE; done one-cycle pulse at burst end
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic [ADDR_WIDTH-1:0] ramAddr,
  output logic                  ramRead,
  output logic                  ramWriteEn,
  input  logic [DATA_WIDTH-1:0] ramDout,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  busy,
  output logic                  done
);
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] addr, remaining;
  logic inflight;
  logic full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  assign ramAddr = addr;
  assign ramWriteEn = 1'b0;
  // reserve a buffer slot for every read still in flight so returning data never overflows
  assign ramRead = state == RUN && !full && (int'(count) + int'(inflight) < FIFO_DEPTH);
  assign outValid = !empty;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? (length == '0 ? DONE : RUN) : IDLE;
      RUN:     state_n = (ramRead && remaining == ADDR_WIDTH'(1)) ? DRAIN : RUN;
      DRAIN:   state_n = (empty && !inflight) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      inflight <= 1'b0;
    end else begin
      state <= state_n;
      inflight <= ramRead;
      if (state == IDLE && start) begin
        addr <= baseAddr;
        remaining <= length;
      end else if (ramRead) begin
        addr <= addr + ADDR_WIDTH'(1);
        remaining <= remaining - ADDR_WIDTH'(1);
      end
    end
  end
  stream_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(inflight),
    .wr_data(ramDout),
    .rd_en(outReady),
    .rd_data(outData),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed scoreboard bench for ram_stream_reader with a sync_ram model (word i = 2i+1)
module tb_ram_stream_reader;
  logic clk = 0, rst = 1, start = 0, outReady = 1;
  logic [15:0] baseAddr = 0, length = 0, ramAddr;
  logic ramRead, ramWriteEn, outValid, busy, done;
  logic [31:0] ramDout = 0, outData;
  int total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [15:0] addr_log[$];
  int occ = 0;
  logic infl = 0;
  int done_cnt = 0, rd_cnt = 0, val_cnt = 0;

  always #5 clk = ~clk;

  ram_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .baseAddr(baseAddr), .length(length),
    .ramAddr(ramAddr), .ramRead(ramRead), .ramWriteEn(ramWriteEn), .ramDout(ramDout),
    .outData(outData), .outValid(outValid), .outReady(outReady), .busy(busy), .done(done)
  );

  always @(posedge clk) if (ramRead) ramDout <= 32'(ramAddr) * 2 + 1;

  always @(posedge clk or posedge rst)
    if (rst) begin
      occ <= 0;
      infl <= 0;
    end else begin
      occ <= occ + int'(infl) - int'(outValid && outReady);
      infl <= ramRead;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      check("wen", ramWriteEn, 0);
      check("valid_occ", outValid, occ != 0);
      if (ramRead) begin
        rd_cnt++;
        addr_log.push_back(ramAddr);
        check("stall", 32'(occ + int'(infl) < 4), 1);
      end
      if (outValid) val_cnt++;
      if (done) done_cnt++;
      if (outValid && outReady) begin
        if (exp_q.size() != 0) check("data", outData, exp_q.pop_front());
        else begin
          total++;
          bad++;
          $error("FAIL extra_word got=%0h exp=none", outData);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_addr"}, ramAddr, 0);
    check({tag, "_rd"}, ramRead, 0);
    check({tag, "_data"}, outData, 0);
    check({tag, "_valid"}, outValid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic do_start(input logic [15:0] b, input logic [15:0] l);
    baseAddr = b;
    length = l;
    start = 1;
    for (int i = 0; i < int'(l); i++) begin
      logic [15:0] a;
      a = b + 16'(i);
      exp_q.push_back(32'(a) * 2 + 1);
    end
    tick();
    start = 0;
  endtask

  task automatic finish_burst(input bit toggle, input int d0);
    int n = 0;
    bit seen = 0;
    logic [3:0] pat = 4'b1001;
    while (!seen && n < 300) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        @(posedge clk);
        #1;
        if (toggle) outReady = pat[n % 4];
        n++;
      end
    end
    outReady = 1;
    check("done_seen", seen, 1);
    check("busy_at_done", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("sb_empty", 32'(exp_q.size()), 0);
    check("done_cnt", 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    logic [15:0] wrap_a [4];
    int r0, v0;
    wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    #3;
    chk_zero("reset");
    tick();
    tick();
    rst = 0;
    tick();
    // basic burst, latency and back-to-back output
    do_start(16'h0000, 16'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check("lat_valid", outValid, k >= 3 && k <= 6);
    end
    finish_burst(0, done_cnt);
    // backpressure with stall
    tick();
    do_start(16'h0010, 16'd8);
    finish_burst(1, done_cnt);
    // address wrap
    tick();
    addr_log.delete();
    do_start(16'hFFFE, 16'd4);
    finish_burst(0, done_cnt);
    check("wrap_n", 32'(addr_log.size()), 4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) check("wrap_addr", addr_log[i], wrap_a[i]);
    // empty burst
    tick();
    r0 = rd_cnt;
    v0 = val_cnt;
    do_start(16'h0000, 16'd0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_busy", busy, 1);
    @(negedge clk);
    check("len0_done_off", done, 0);
    check("len0_idle", busy, 0);
    check("len0_reads", 32'(rd_cnt), 32'(r0));
    check("len0_valid", 32'(val_cnt), 32'(v0));
    // reset mid-burst
    tick();
    do_start(16'h0000, 16'd16);
    tick();
    rst = 1;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    tick();
    tick();
    rst = 0;
    tick();
    do_start(16'h0005, 16'd2);
    finish_burst(0, done_cnt);
    // start while busy is ignored
    tick();
    addr_log.delete();
    do_start(16'h0000, 16'd4);
    baseAddr = 16'h0100;
    length = 16'd9;
    start = 1;
    tick();
    start = 0;
    finish_burst(0, done_cnt);
    check("busy_start_n", 32'(addr_log.size()), 4);
    if (addr_log.size() == 4) check("busy_start_last", addr_log[3], 16'h0003);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
